// File: rtl/parity_uart_tx_if.sv
// Byte-source and serial-line signals of parity_uart_tx.
// master: the byte source; slave: the transmitter.
interface parity_uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       parity_odd;
  logic       tx_ready;
  logic       tx_out;
  logic       busy;
  logic       done;

  modport master (
    output tx_data, tx_valid, parity_odd,
    input  tx_ready, tx_out, busy, done
  );

  modport slave (
    input  tx_data, tx_valid, parity_odd,
    output tx_ready, tx_out, busy, done
  );
endinterface

// File: rtl/parity_uart_tx.sv
// Serial transmitter: start, 8 data bits LSB-first, per-frame even/odd parity, stop.
// All outputs are registered; each bit lasts CLKS_PER_BIT cycles.
module parity_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input logic              clk,
  input logic              rst_n,
  parity_uart_tx_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(CLKS_PER_BIT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             tx_out_q, tx_out_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic accept;
  logic tick;

  assign accept = bus.tx_valid && ready_q;
  assign tick   = (cnt_q == CntMax);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_out_q <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_out_q <= tx_out_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StStart;
      StStart:  if (tick) state_d = StData;
      StData:   if (tick && idx_q == 3'd7) state_d = StParity;
      StParity: if (tick) state_d = StStop;
      StStop:   if (tick) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tx_out_d = tx_out_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (accept) begin
          shift_d  = bus.tx_data;
          par_d    = ^bus.tx_data ^ bus.parity_odd;
          idx_d    = 3'd0;
          tx_out_d = 1'b0;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
        end
      end
      StStart: if (tick) tx_out_d = shift_q[0];
      StData: begin
        if (tick) begin
          if (idx_q == 3'd7) begin
            tx_out_d = par_q;
          end else begin
            // Bit 0 of shift_q is always the bit currently on the line.
            idx_d    = idx_q + 3'd1;
            shift_d  = shift_q >> 1;
            tx_out_d = shift_q[1];
          end
        end
      end
      StParity: if (tick) tx_out_d = 1'b1;
      StStop: begin
        if (tick) begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        cnt_d    = '0;
        tx_out_d = 1'b1;
        ready_d  = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  assign bus.tx_out   = tx_out_q;
  assign bus.tx_ready = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
